miner_core_compress: RTL and testbench

//  SHA-256 compression engine sitting directly downstream of the message scheduling array.

---
 rtl/miner_core_compress.sv | 164 ++++++++++++++++
 tb/tb_miner_core_compress.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_core_compress.sv
// SHA-256 compression engine: 64 rounds, one per clock, then a final
// chaining add. Ports:
//   clk, n_rst        clock, async active-low reset
//   comp_en           start request, taken only when idle
//   w[0:63][0:31]     message schedule, w[0] first, bit 0 = MSB
//   h_in[0:255]       chaining value, H0 in bits [0:31]
//   busy              high while rounds or the final add are in flight
//   done              one-cycle pulse when hash_out updates
//   hash_out[0:255]   result, H0 in bits [0:31], held until next job
module miner_core_compress (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              comp_en,
  input  logic [0:63][0:31] w,
  input  logic [0:255]      h_in,
  output logic              busy,
  output logic              done,
  output logic [0:255]      hash_out
);

  localparam int ROUNDS = 64;

  localparam logic [0:ROUNDS-1][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       rnd_q, rnd_d;
  // working variables, index 0 = a ... 7 = h
  logic [7:0][31:0] wv_q, wv_d;
  logic [0:255]     hbase_q, hbase_d;
  logic [0:255]     hash_q, hash_d;
  logic             done_q, done_d;

  function automatic logic [31:0] bsig0(
    input logic [31:0] x
  );
    return {x[1:0],  x[31:2]}  ^
           {x[12:0], x[31:13]} ^
           {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(
    input logic [31:0] x
  );
    return {x[5:0],  x[31:6]}  ^
           {x[10:0], x[31:11]} ^
           {x[24:0], x[31:25]};
  endfunction

  logic [31:0] va, vb, vc, vd;
  logic [31:0] ve, vf, vg, vh;
  logic [31:0] s0, s1, ch, maj;
  logic [31:0] kt, wt, t1, t2;

  assign va = wv_q[0];
  assign vb = wv_q[1];
  assign vc = wv_q[2];
  assign vd = wv_q[3];
  assign ve = wv_q[4];
  assign vf = wv_q[5];
  assign vg = wv_q[6];
  assign vh = wv_q[7];

  assign s1  = bsig1(ve);
  assign ch  = (ve & vf) ^ (~ve & vg);
  assign s0  = bsig0(va);
  assign maj = (va & vb) ^ (va & vc) ^ (vb & vc);
  assign kt  = K[rnd_q];
  assign wt  = w[rnd_q];
  assign t1  = vh + s1 + ch + kt + wt;
  assign t2  = s0 + maj;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    wv_d    = wv_q;
    hbase_d = hbase_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (comp_en) begin
          for (int i = 0; i < 8; i++) begin
            wv_d[i] = h_in[i*32 +: 32];
          end
          hbase_d = h_in;
          rnd_d   = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        wv_d[7] = vg;
        wv_d[6] = vf;
        wv_d[5] = ve;
        wv_d[4] = vd + t1;
        wv_d[3] = vc;
        wv_d[2] = vb;
        wv_d[1] = va;
        wv_d[0] = t1 + t2;
        // 6-bit counter wraps to 0 on the same edge we leave
        rnd_d   = rnd_q + 6'd1;
        if (rnd_q == 6'(ROUNDS - 1)) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[i*32 +: 32] =
            hbase_q[i*32 +: 32] + wv_q[i];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      wv_q    <= '0;
      hbase_q <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      wv_q    <= wv_d;
      hbase_q <= hbase_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hash_out = hash_q;

endmodule

// File: tb/tb_miner_core_compress.sv
// Directed bench for miner_core_compress: known digests,
// latency, reset abort, busy-ignore, back-to-back, carry, idle.
module tb_miner_core_compress;

  typedef logic [0:63][31:0] sched_t;

  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         comp_en;
  sched_t       w_v;
  logic [255:0] h_v;
  logic         busy;
  logic         done;
  logic [0:255] hash_out;

  int checks = 0;
  int errors = 0;

  sched_t sch_abc;
  sched_t sch_empty;

  always #5 clk = ~clk;

  miner_core_compress dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .comp_en  (comp_en),
    .w        (w_v),
    .h_in     (h_v),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
  );

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t expand(
    input logic [511:0] blk
  );
    sched_t s;
    logic [31:0] a, b;
    for (int t = 0; t < 16; t++) begin
      s[t] = blk[511 - 32*t -: 32];
    end
    for (int t = 16; t < 64; t++) begin
      a = rotr(s[t-2], 17) ^ rotr(s[t-2], 19) ^ (s[t-2] >> 10);
      b = rotr(s[t-15], 7) ^ rotr(s[t-15], 18) ^ (s[t-15] >> 3);
      s[t] = a + s[t-7] + b + s[t-16];
    end
    return s;
  endfunction

  function automatic logic [255:0] ref_compress(
    input logic [255:0] hv,
    input sched_t       ws
  );
    logic [31:0] v  [8];
    logic [31:0] hh [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hv[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7]
         + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + KT[t] + ws[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[255 - 32*i -: 32] = hh[i] + v[i];
    end
    return r;
  endfunction

  // edges from the start edge up to the one that shows done
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 200);
  endtask

  task automatic test_reset();
    comp_en = 1'b0;
    w_v     = '0;
    h_v     = '0;
    n_rst   = 1'b1;
    #2;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (hash_out !== 256'h0) begin
      errors++;
      $display("FAIL reset_hash: got %h expected 0", hash_out);
    end
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_abc();
    int cyc;
    h_v = IV;
    w_v = sch_abc;
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    comp_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abc_busy: got %b expected 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 65) begin
      errors++;
      $display("FAIL abc_latency: got %0d expected 65", cyc);
    end
    checks++;
    if (hash_out !== DIG_ABC) begin
      errors++;
      $display("FAIL abc_digest: got %h expected %h",
               hash_out, DIG_ABC);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abc_done_width: got done=%b busy=%b expected 0 0",
               done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    h_v = IV;
    w_v = sch_abc;
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    comp_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b expected 1", busy);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got busy=%b done=%b expected 0 0",
               busy, done);
    end
    checks++;
    if (hash_out !== 256'h0) begin
      errors++;
      $display("FAIL abort_hash: got %h expected 0", hash_out);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", seen);
    end
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    comp_en = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc !== 65 || hash_out !== DIG_ABC) begin
      errors++;
      $display("FAIL abort_rerun: got lat=%0d %h expected 65 %h",
               cyc, hash_out, DIG_ABC);
    end
  endtask

  task automatic test_ignore_busy();
    int cyc;
    int seen;
    w_v = sch_empty;
    h_v = IV;
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    comp_en = 1'b0;
    w_v = sch_empty;
    cyc = 0;
    do begin
      comp_en = (cyc == 5 || cyc == 63);
      @(posedge clk);
      #1;
      cyc++;
    end while (!done && cyc < 200);
    comp_en = 1'b0;
    checks++;
    if (cyc !== 65) begin
      errors++;
      $display("FAIL ignore_latency: got %0d expected 65", cyc);
    end
    checks++;
    if (hash_out !== DIG_EMPTY) begin
      errors++;
      $display("FAIL ignore_digest: got %h expected %h",
               hash_out, DIG_EMPTY);
    end
    seen = 0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ignore_extra_job: got %0d active cycles expected 0",
               seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    h_v = IV;
    w_v = sch_abc;
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    wait_done(cyc);
    checks++;
    if (cyc !== 65 || hash_out !== DIG_ABC) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d %h expected 65 %h",
               cyc, hash_out, DIG_ABC);
    end
    w_v = sch_empty;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0",
               busy, done);
    end
    wait_done(cyc);
    comp_en = 1'b0;
    checks++;
    if (cyc + 1 !== 66) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 66", cyc + 1);
    end
    checks++;
    if (hash_out !== DIG_EMPTY) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h",
               hash_out, DIG_EMPTY);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_carry();
    int cyc;
    logic [255:0] exp;
    exp = ref_compress({256{1'b1}}, '0);
    h_v = {256{1'b1}};
    w_v = '0;
    comp_en = 1'b1;
    @(posedge clk);
    #1;
    comp_en = 1'b0;
    // h_in is latched at start, later changes must not matter
    h_v = '0;
    wait_done(cyc);
    checks++;
    if (cyc !== 65) begin
      errors++;
      $display("FAIL carry_latency: got %0d expected 65", cyc);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hash_out[i*32 +: 32] !== exp[255 - 32*i -: 32]) begin
        errors++;
        $display("FAIL carry_word%0d: got %h expected %h", i,
                 hash_out[i*32 +: 32], exp[255 - 32*i -: 32]);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [255:0] held;
    held = ref_compress({256{1'b1}}, '0);
    comp_en = 1'b0;
    h_v = IV;
    w_v = sch_abc;
    repeat (100) begin
      @(posedge clk);
      #1;
      checks++;
      if (hash_out !== held || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: got %h b=%b d=%b expected %h 0 0",
                 hash_out, busy, done, held);
      end
    end
  endtask

  initial begin
    sch_abc   = expand({32'h61626380, 416'h0, 64'h18});
    sch_empty = expand({32'h80000000, 480'h0});
    test_reset();
    test_abc();
    test_reset_mid();
    test_ignore_busy();
    test_back_to_back();
    test_carry();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
